// File: rtl/axis_frame_len_enforcer.sv
// Byte-wide AXI4-Stream frame length enforcer: zero-pads runts to MIN_LEN, truncates at MAX_LEN.
// Optional saturating frame/pad/truncation counters when AXIS_FRAME_LEN_STATS_EN is defined.
module axis_frame_len_enforcer #(
    parameter int                    MIN_LEN              = 60,
    parameter int                    MAX_LEN              = 1514,
    parameter int                    USER_WIDTH           = 1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  status_pad,
    output logic                  status_trunc
`ifdef AXIS_FRAME_LEN_STATS_EN
    ,
    output logic [31:0]           stat_frames_o,
    output logic [31:0]           stat_padded_o,
    output logic [31:0]           stat_trunc_o
`endif
);

    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {PASS, PAD, DROP} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_inc;
    logic [USER_WIDTH-1:0] pad_user;
    logic                  load_ok;
    logic                  s_fire;

    assign load_ok = ~m_axis_tvalid | m_axis_tready;
    assign cnt_inc = cnt + CW'(1);
    assign s_fire  = s_axis_tvalid & s_axis_tready;

    always_comb begin
        s_axis_tready = 1'b0;
        case (state)
            PASS:    s_axis_tready = load_ok;
            DROP:    s_axis_tready = 1'b1;
            default: s_axis_tready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= PASS;
            cnt           <= '0;
            pad_user      <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            status_pad    <= 1'b0;
            status_trunc  <= 1'b0;
        end else begin
            status_pad   <= 1'b0;
            status_trunc <= 1'b0;
            // A load below overrides this clear in the same cycle.
            if (m_axis_tready)
                m_axis_tvalid <= 1'b0;
            case (state)
                PASS: begin
                    if (s_fire) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tuser  <= s_axis_tuser;
                        m_axis_tlast  <= 1'b0;
                        cnt           <= cnt_inc;
                        if (s_axis_tlast) begin
                            if (cnt_inc >= CW'(MIN_LEN)) begin
                                m_axis_tlast <= 1'b1;
                                cnt          <= '0;
                            end else begin
                                pad_user <= s_axis_tuser;
                                state    <= PAD;
                            end
                        end else if (cnt_inc == CW'(MAX_LEN)) begin
                            m_axis_tlast <= 1'b1;
                            m_axis_tuser <= (s_axis_tuser & ~USER_BAD_FRAME_MASK) |
                                            (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK);
                            status_trunc <= 1'b1;
                            cnt          <= '0;
                            state        <= DROP;
                        end
                    end
                end
                PAD: begin
                    if (load_ok) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= '0;
                        m_axis_tuser  <= pad_user;
                        if (cnt_inc == CW'(MIN_LEN)) begin
                            m_axis_tlast <= 1'b1;
                            status_pad   <= 1'b1;
                            cnt          <= '0;
                            state        <= PASS;
                        end else begin
                            m_axis_tlast <= 1'b0;
                            cnt          <= cnt_inc;
                        end
                    end
                end
                DROP: begin
                    // Remainder of an overlong frame is swallowed up to its tlast.
                    if (s_fire && s_axis_tlast)
                        state <= PASS;
                end
                default: state <= PASS;
            endcase
        end
    end

`ifdef AXIS_FRAME_LEN_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_frames_o <= '0;
            stat_padded_o <= '0;
            stat_trunc_o  <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast && stat_frames_o != 32'hFFFF_FFFF)
                stat_frames_o <= stat_frames_o + 32'd1;
            if (status_pad && stat_padded_o != 32'hFFFF_FFFF)
                stat_padded_o <= stat_padded_o + 32'd1;
            if (status_trunc && stat_trunc_o != 32'hFFFF_FFFF)
                stat_trunc_o <= stat_trunc_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_frame_len_enforcer.sv
// Self-checking bench for axis_frame_len_enforcer: directed frame table, corner sequences
// and randomized frames against a frame-level reference model.
module tb_axis_frame_len_enforcer;

    localparam int   MIN  = 60;
    localparam int   MAX  = 1514;
    localparam int   UW   = 1;
    localparam logic BADV = 1'b1;
    localparam logic BADM = 1'b1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [UW-1:0] s_axis_tuser = '0;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [UW-1:0] m_axis_tuser;
    logic          status_pad;
    logic          status_trunc;
`ifdef AXIS_FRAME_LEN_STATS_EN
    logic [31:0]   stat_frames_o, stat_padded_o, stat_trunc_o;
`endif

    axis_frame_len_enforcer #(
        .MIN_LEN(MIN), .MAX_LEN(MAX), .USER_WIDTH(UW),
        .USER_BAD_FRAME_VALUE(BADV), .USER_BAD_FRAME_MASK(BADM)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser),
        .status_pad(status_pad), .status_trunc(status_trunc)
`ifdef AXIS_FRAME_LEN_STATS_EN
        , .stat_frames_o(stat_frames_o), .stat_padded_o(stat_padded_o),
        .stat_trunc_o(stat_trunc_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    d;
        logic          l;
        logic [UW-1:0] u;
    } beat_t;

    typedef struct {
        int   len;
        int   exp_out;
        int   exp_pad;
        int   exp_trunc;
        logic exp_last_user;
    } vec_t;

    beat_t   expq[$];
    int      checks = 0, errors = 0;
    bit      sb_en = 1'b1, rnd_rdy = 1'b0, gaps = 1'b0, mark_first = 1'b0;
    int      cyc = 0, t_first = 0, t_last = 0;
    int      n_out = 0, n_pad = 0, n_trunc = 0;
    int      m_frames = 0, m_pads = 0, m_truncs = 0;
    logic    last_user = 1'b0;
    logic    prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [7:0]    prev_d = '0;
    logic [UW-1:0] prev_u = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) m_axis_tready = 1'($urandom % 2);
            else         m_axis_tready = 1'b1;
        end
    end

    // Output monitor: scoreboard, stall stability, status alignment.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_v = 1'b0; m_frames = 0; m_pads = 0; m_truncs = 0;
                continue;
            end
            if (prev_v && !prev_r)
                chk("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser},
                    {1'b1, prev_d, prev_l, prev_u});
            if (status_pad) begin
                n_pad++; m_pads++;
                chk("pad_on_last", {m_axis_tvalid, m_axis_tlast}, 2'b11);
            end
            if (status_trunc) begin
                n_trunc++; m_truncs++;
                chk("trunc_on_last", {m_axis_tvalid, m_axis_tlast}, 2'b11);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                n_out++;
                if (m_axis_tlast) begin
                    last_user = m_axis_tuser;
                    m_frames++;
                end
                if (mark_first) begin
                    t_first = cyc;
                    mark_first = 1'b0;
                end
                t_last = cyc;
                if (sb_en) begin
                    if (expq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat: got %0h with nothing expected", m_axis_tdata);
                    end else begin
                        e = expq.pop_front();
                        chk("beat", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, {e.d, e.l, e.u});
                    end
                end
            end
            prev_v = m_axis_tvalid; prev_r = m_axis_tready;
            prev_d = m_axis_tdata;  prev_l = m_axis_tlast; prev_u = m_axis_tuser;
        end
    end

    task automatic drive_beat(input logic [7:0] d, input logic l, input logic [UW-1:0] u, input bit lat);
        int w = 0;
        s_axis_tdata = d; s_axis_tlast = l; s_axis_tuser = u; s_axis_tvalid = 1'b1;
        do begin
            @(negedge clk);
            w++;
        end while (!s_axis_tready && w < 10000);
        if (!s_axis_tready) begin
            checks++; errors++;
            $display("FAIL input_accept_timeout: got tready=0 required 1");
        end
        @(posedge clk);
        #1;
        if (lat) chk("latency", {m_axis_tvalid, m_axis_tdata}, {1'b1, d});
        s_axis_tvalid = 1'b0;
        if (gaps && ($urandom % 4 == 0)) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model works on whole frames: clip to MAX, extend to MIN.
    task automatic send_frame(input int len, input bit rnd, input bit lat);
        logic [7:0]    dq[$];
        logic [UW-1:0] uq[$];
        int            olen;
        beat_t         b;
        for (int i = 0; i < len; i++) begin
            dq.push_back(rnd ? 8'($urandom) : 8'(i));
            uq.push_back(rnd ? UW'($urandom % 2) : '0);
        end
        olen = (len > MAX) ? MAX : ((len < MIN) ? MIN : len);
        if (sb_en) begin
            for (int i = 0; i < olen; i++) begin
                b.d = (i < len) ? dq[i] : 8'h00;
                b.u = (i < len) ? uq[i] : uq[len-1];
                b.l = (i == olen - 1);
                if (len > MAX && i == MAX - 1) b.u = (b.u & ~BADM) | (BADV & BADM);
                expq.push_back(b);
            end
        end
        for (int i = 0; i < len; i++)
            drive_beat(dq[i], i == len - 1, uq[i], lat && i == 0);
    endtask

    task automatic drain();
        int w = 0;
        while ((expq.size() != 0 || m_axis_tvalid) && w < 20000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d beats pending required 0", expq.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[10];
        int   o, p, t, c, ep, et, len, r;
        tbl[0] = '{100,  100,  0, 0, 1'b0};
        tbl[1] = '{10,   60,   1, 0, 1'b0};
        tbl[2] = '{1600, 1514, 0, 1, 1'b1};
        tbl[3] = '{60,   60,   0, 0, 1'b0};
        tbl[4] = '{1514, 1514, 0, 0, 1'b0};
        tbl[5] = '{1,    60,   1, 0, 1'b0};
        tbl[6] = '{59,   60,   1, 0, 1'b0};
        tbl[7] = '{61,   61,   0, 0, 1'b0};
        tbl[8] = '{1515, 1514, 0, 1, 1'b1};
        tbl[9] = '{1513, 1513, 0, 0, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset_outputs", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser,
                              status_pad, status_trunc}, '0);
        chk("reset_ready", {31'd0, s_axis_tready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            o = n_out; p = n_pad; t = n_trunc;
            send_frame(tbl[k].len, 1'b0, k == 0);
            drain();
            chk($sformatf("tbl%0d_out_len", tbl[k].len), n_out - o, tbl[k].exp_out);
            chk($sformatf("tbl%0d_pad", tbl[k].len), n_pad - p, tbl[k].exp_pad);
            chk($sformatf("tbl%0d_trunc", tbl[k].len), n_trunc - t, tbl[k].exp_trunc);
            chk($sformatf("tbl%0d_last_user", tbl[k].len), {31'd0, last_user}, {31'd0, tbl[k].exp_last_user});
        end

        // Input is held off for exactly the pad stretch.
        send_frame(10, 1'b0, 1'b0);
        c = 0;
        @(negedge clk);
        while (!s_axis_tready && c < 200) begin
            c++;
            @(negedge clk);
        end
        chk("pad_tready_low", c, 50);
        drain();

        // Padded frame followed by a normal one: no bubble on the output.
        mark_first = 1'b1;
        send_frame(10, 1'b1, 1'b0);
        send_frame(70, 1'b1, 1'b0);
        drain();
        chk("b2b_span", t_last - t_first, 129);

        // Reset in the middle of a frame, then a clean 70-byte frame.
        sb_en = 1'b0;
        for (int i = 0; i < 30; i++) drive_beat(8'(i), 1'b0, '0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expq.delete();
        sb_en = 1'b1;
        o = n_out; p = n_pad;
        send_frame(70, 1'b1, 1'b0);
        drain();
        chk("post_rst_len", n_out - o, 70);
        chk("post_rst_pad", n_pad - p, 0);

        // Randomized frames with downstream backpressure and input gaps.
        rnd_rdy = 1'b1; gaps = 1'b1;
        p = n_pad; t = n_trunc; ep = 0; et = 0;
        for (int k = 0; k < 200; k++) begin
            r = $urandom % 100;
            if (r < 2)       len = $urandom_range(1400, 1600);
            else if (r < 10) len = $urandom_range(55, 65);
            else             len = $urandom_range(1, 120);
            ep += (len < MIN) ? 1 : 0;
            et += (len > MAX) ? 1 : 0;
            send_frame(len, 1'b1, 1'b0);
        end
        drain();
        chk("rand_pads", n_pad - p, ep);
        chk("rand_truncs", n_trunc - t, et);
        chk("queue_empty", expq.size(), 0);
`ifdef AXIS_FRAME_LEN_STATS_EN
        chk("stat_frames", stat_frames_o, m_frames);
        chk("stat_padded", stat_padded_o, m_pads);
        chk("stat_trunc", stat_trunc_o, m_truncs);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion required finish before time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axis_frame_len_enforcer.md
Name: axis_frame_len_enforcer

Overview:
- Byte-wide AXI4-Stream stage on the Ethernet TX path, directly upstream of the TX async CDC FIFO; its master port feeds the FIFO's s_axis_* interface.
- Pads runt frames with zero bytes up to MIN_LEN.
- Truncates frames that reach MAX_LEN without tlast, marks them bad via tuser, and discards the remainder.
- Registered output with full-throughput handshake.

Parameters:
- MIN_LEN, 60, minimum output frame length in bytes (FCS excluded); must be >= 1.
- MAX_LEN, 1514, maximum output frame length in bytes; must be > MIN_LEN.
- USER_WIDTH, 1, tuser width.
- USER_BAD_FRAME_VALUE, 1'b1, tuser value driven on the last beat of a truncated frame.
- USER_BAD_FRAME_MASK, 1'b1, tuser bits overwritten with USER_BAD_FRAME_VALUE on truncation.

Ports:
- clk, input, 1, sole clock.
- rst, input, 1, asynchronous active-high reset.
- s_axis_tdata, input, 8, input byte.
- s_axis_tvalid, input, 1, input valid.
- s_axis_tready, output, 1, input ready.
- s_axis_tlast, input, 1, input end of frame.
- s_axis_tuser, input, USER_WIDTH, input sideband.
- m_axis_tdata, output, 8, output byte.
- m_axis_tvalid, output, 1, output valid.
- m_axis_tready, input, 1, downstream ready (from the async FIFO).
- m_axis_tlast, output, 1, output end of frame.
- m_axis_tuser, output, USER_WIDTH, output sideband.
- status_pad, output, 1, one-cycle pulse when a padded frame's last beat is loaded.
- status_trunc, output, 1, one-cycle pulse when a truncated frame's last beat is loaded.

Behaviour:
- Single clock domain: clk; reset is asynchronous and active-high: rst.
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, status_pad=0, status_trunc=0, state=PASS, cnt=0.
- cnt width is clog2(MAX_LEN+1). cnt holds the bytes already emitted in the current output frame.
- Output register:
  - load_ok = ~m_axis_tvalid | m_axis_tready.
  - The register loads when load_ok and a beat is produced; m_axis_tvalid clears when m_axis_tready and nothing is loaded.
  - Latency is one cycle from input acceptance to m_axis_tvalid.
- State PASS:
  - s_axis_tready = load_ok. An accepted beat is copied to the output register and n = cnt+1.
  - tlast=1 and n >= MIN_LEN: out tlast=1, cnt<=0, stay PASS.
  - tlast=1 and n < MIN_LEN: out tlast=0, latch tuser into pad_user, cnt<=n, go PAD.
  - tlast=0 and n == MAX_LEN: out tlast=1, out tuser = (tuser & ~MASK) | (VALUE & MASK), status_trunc pulse, cnt<=0, go DROP.
  - tlast=1 and n == MAX_LEN: normal end, no truncation.
  - Otherwise: cnt<=n.
- State PAD:
  - s_axis_tready=0. Each load_ok cycle loads tdata=0 and tuser=pad_user; n=cnt+1.
  - When n == MIN_LEN: tlast=1, status_pad pulse, cnt<=0, go PASS. Otherwise tlast=0 and cnt<=n.
- State DROP:
  - s_axis_tready=1 and nothing is loaded.
  - An accepted beat with tlast=1 returns to PASS with cnt=0. Beats without tlast are discarded.
- Boundary cases:
  - A 1-byte frame (tlast on the first beat) pads MIN_LEN-1 zero bytes.
  - A frame of exactly MIN_LEN or MAX_LEN bytes passes unchanged with status low.
  - Back-to-back frames with m_axis_tready held 1 sustain one beat per cycle. A padded frame adds no idle cycle after the pad.
  - Downstream stall (m_axis_tready=0 with valid set) holds all output fields stable; the held beat is never overwritten.
  - Reset asserted mid-frame returns to PASS with cnt=0 and clears the output register. Bytes in flight are lost; the next input beat starts a new frame.
- status_pad and status_trunc are registered, one cycle high, and coincide with the cycle the last beat is loaded.

Optional Feature:
- Macro: AXIS_FRAME_LEN_STATS_EN.
- When defined, adds three output ports, each 32-bit, saturating and reset to 0:
  - stat_frames_o: increments on each output last-beat handshake.
  - stat_padded_o: increments on status_pad.
  - stat_trunc_o: increments on status_trunc.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- 100-byte frame 0x00..0x63, m_axis_tready=1 -> identical 100 beats, tlast on byte 100, tuser=0, no status pulses, 1-cycle latency.
- 10-byte frame with tuser=0 -> 10 data bytes, then 50 zero bytes. tlast only on beat 60, status_pad pulses once, s_axis_tready=0 during the 50 pad cycles.
- 1600-byte frame without early tlast, MAX_LEN=1514 -> 1514 beats out, beat 1514 has tlast=1 and tuser=1, status_trunc pulses. The remaining 86 input bytes are accepted and dropped; the next frame passes normally.
- Exact 60-byte and exact 1514-byte frames -> pass unchanged, no pad, no truncation.
- Random m_axis_tready toggling (50%) over 200 mixed-length frames -> output data matches the reference model, no beat lost or duplicated, outputs stable while stalled.
- rst asserted at byte 30 of a 40-byte frame, then a 70-byte frame -> m_axis_tvalid=0 right after reset; the 70-byte frame is emitted alone with no pad.
